date_counter: RTL and testbench

- BCD calendar counter for the millennium clock; holds the current day, month and year as BCD digits.
- Advances one day per day_tick from the time-of-day chain.
- Drives month/year digits into day_of_month combinationally and consumes its max_days result to decide day rollover.
- Also accepts a date-set request, with month sanitising and day clamping against max_days.

---
 rtl/date_counter_if.sv | 35 +++
 rtl/date_counter.sv | 189 ++++++++++++++++++
 tb/tb_date_counter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/date_counter_if.sv
// rtl/date_counter_if.sv - tick, date-set and BCD date bus between date_counter and its neighbours
interface date_counter_if;
    logic        day_tick;
    logic [4:0]  max_days;
    logic        set_req;
    logic [7:0]  set_day;
    logic [7:0]  set_month;
    logic [15:0] set_year;
    logic [3:0]  day_unit;
    logic [3:0]  day_ten;
    logic [3:0]  month_unit;
    logic [3:0]  month_ten;
    logic [3:0]  year_unit;
    logic [3:0]  year_ten;
    logic [3:0]  year_hundered;
    logic [3:0]  year_thousand;
    logic        busy;
    logic        set_ack;
    logic        set_err;
    logic        year_wrap;

    modport slave (
        input  day_tick, max_days, set_req, set_day, set_month, set_year,
        output day_unit, day_ten, month_unit, month_ten,
               year_unit, year_ten, year_hundered, year_thousand,
               busy, set_ack, set_err, year_wrap
    );

    modport master (
        output day_tick, max_days, set_req, set_day, set_month, set_year,
        input  day_unit, day_ten, month_unit, month_ten,
               year_unit, year_ten, year_hundered, year_thousand,
               busy, set_ack, set_err, year_wrap
    );
endinterface

// File: rtl/date_counter.sv
// rtl/date_counter.sv - BCD day/month/year calendar counter with date-set sequence
// Optional: DATE_COUNTER_MILLENNIUM_HOLD_EN freezes the date at 9999-12-31 instead of wrapping.
module date_counter #(
    parameter logic [15:0] RST_YEAR  = 16'h2000,
    parameter logic [7:0]  RST_MONTH = 8'h01,
    parameter logic [7:0]  RST_DAY   = 8'h01
) (
    input  logic          clk,
    input  logic          rst_n,
    date_counter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SET_LOAD  = 2'd1,
        SET_CLAMP = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_day, w_day_nxt;
    logic [7:0]  r_month, w_month_nxt;
    logic [15:0] r_year, w_year_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_set_ack, w_set_ack_nxt;
    logic        r_set_err, w_set_err_nxt;
    logic        r_year_wrap, w_year_wrap_nxt;

    logic [6:0]  w_day_bin;
    logic [6:0]  w_max_bin;
    logic [6:0]  w_set_month_bin;
    logic        w_set_ok;
    logic [7:0]  w_set_month_clean;
    logic [7:0]  w_set_day_clean;

    function automatic logic [6:0] bcd2_bin(input logic [7:0] v);
        return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
    endfunction

    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bin_to_bcd2(input logic [4:0] b);
        if (b >= 5'd30) return {4'd3, 4'(b - 5'd30)};
        if (b >= 5'd20) return {4'd2, 4'(b - 5'd20)};
        if (b >= 5'd10) return {4'd1, 4'(b - 5'd10)};
        return {4'd0, b[3:0]};
    endfunction

    // Ripple the +1 from the unit digit upward; each 9 becomes 0 and passes the carry on.
    function automatic logic [15:0] year_inc(input logic [15:0] y);
        logic [15:0] r;
        logic        c;
        r = y;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (y[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = y[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic digits_ok(input logic [15:0] y, input logic [7:0] m, input logic [7:0] d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (y[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (m[4*i +: 4] > 4'd9) ok = 1'b0;
            if (d[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    assign w_day_bin         = bcd2_bin(r_day);
    assign w_max_bin         = {2'b00, bus.max_days};
    assign w_set_month_bin   = bcd2_bin(bus.set_month);
    assign w_set_ok          = digits_ok(bus.set_year, bus.set_month, bus.set_day);
    assign w_set_month_clean = (w_set_month_bin == 7'd0)  ? 8'h01 :
                               (w_set_month_bin > 7'd12)  ? 8'h12 : bus.set_month;
    assign w_set_day_clean   = (bus.set_day == 8'h00) ? 8'h01 : bus.set_day;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_day       <= RST_DAY;
            r_month     <= RST_MONTH;
            r_year      <= RST_YEAR;
            r_busy      <= 1'b0;
            r_set_ack   <= 1'b0;
            r_set_err   <= 1'b0;
            r_year_wrap <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_day       <= w_day_nxt;
            r_month     <= w_month_nxt;
            r_year      <= w_year_nxt;
            r_busy      <= w_busy_nxt;
            r_set_ack   <= w_set_ack_nxt;
            r_set_err   <= w_set_err_nxt;
            r_year_wrap <= w_year_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_day_nxt       = r_day;
        w_month_nxt     = r_month;
        w_year_nxt      = r_year;
        w_busy_nxt      = r_busy;
        w_set_ack_nxt   = 1'b0;
        w_set_err_nxt   = 1'b0;
        w_year_wrap_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.set_req && w_set_ok) begin
                    w_year_nxt  = bus.set_year;
                    w_month_nxt = w_set_month_clean;
                    w_day_nxt   = w_set_day_clean;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SET_LOAD;
                end else begin
                    w_set_err_nxt = bus.set_req;
                    if (bus.day_tick) begin
                        if (w_day_bin < w_max_bin) begin
                            w_day_nxt = bcd2_inc(r_day);
                        end else if (r_month != 8'h12) begin
                            w_day_nxt   = 8'h01;
                            w_month_nxt = bcd2_inc(r_month);
                        end else if (r_year != 16'h9999) begin
                            w_day_nxt   = 8'h01;
                            w_month_nxt = 8'h01;
                            w_year_nxt  = year_inc(r_year);
                        end else begin
`ifdef DATE_COUNTER_MILLENNIUM_HOLD_EN
                            w_day_nxt   = r_day;
`else
                            w_day_nxt       = 8'h01;
                            w_month_nxt     = 8'h01;
                            w_year_nxt      = 16'h0000;
                            w_year_wrap_nxt = 1'b1;
`endif
                        end
                    end
                end
            end
            SET_LOAD: begin
                w_state_nxt = SET_CLAMP;
            end
            SET_CLAMP: begin
                if (w_day_bin > w_max_bin) begin
                    w_day_nxt = bin_to_bcd2(bus.max_days);
                end
                w_set_ack_nxt = 1'b1;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.day_unit      = r_day[3:0];
    assign bus.day_ten       = r_day[7:4];
    assign bus.month_unit    = r_month[3:0];
    assign bus.month_ten     = r_month[7:4];
    assign bus.year_unit     = r_year[3:0];
    assign bus.year_ten      = r_year[7:4];
    assign bus.year_hundered = r_year[11:8];
    assign bus.year_thousand = r_year[15:12];
    assign bus.busy          = r_busy;
    assign bus.set_ack       = r_set_ack;
    assign bus.set_err       = r_set_err;
    assign bus.year_wrap     = r_year_wrap;

endmodule

// File: tb/tb_date_counter.sv
// tb/tb_date_counter.sv - scoreboard bench for date_counter against a calendar model
module tb_date_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    date_counter_if bus();

    date_counter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit drop;
        int date;
        bit wrap;
    } tick_exp_t;

    typedef struct {
        bit err;
        int date;
        int cyc;
    } set_exp_t;

    tick_exp_t tick_q[$];
    set_exp_t  set_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit tick_seen = 1'b0;
    int my, mm, md;

    function automatic int dim(int y, int m);
        bit leap;
        leap = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
        case (m)
            2:           return leap ? 29 : 28;
            4, 6, 9, 11: return 30;
            default:     return 31;
        endcase
    endfunction

    // Neighbouring day_of_month block, driven from the DUT's own month/year outputs.
    int w_dut_y, w_dut_m;
    always_comb begin
        w_dut_y = int'(bus.year_thousand) * 1000 + int'(bus.year_hundered) * 100 +
                  int'(bus.year_ten) * 10 + int'(bus.year_unit);
        w_dut_m = int'(bus.month_ten) * 10 + int'(bus.month_unit);
        bus.max_days = 5'(dim(w_dut_y, w_dut_m));
    end

    function automatic int dut_date();
        return (int'(bus.year_thousand) * 1000 + int'(bus.year_hundered) * 100 +
                int'(bus.year_ten) * 10 + int'(bus.year_unit)) * 10000 +
               (int'(bus.month_ten) * 10 + int'(bus.month_unit)) * 100 +
               int'(bus.day_ten) * 10 + int'(bus.day_unit);
    endfunction

    function automatic int model_date();
        return my * 10000 + mm * 100 + md;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_tick(output bit wrap);
        wrap = 1'b0;
        if (md < dim(my, mm)) begin
            md++;
        end else if (mm < 12) begin
            md = 1;
            mm++;
        end else if (my < 9999) begin
            md = 1;
            mm = 1;
            my++;
        end else begin
`ifndef DATE_COUNTER_MILLENNIUM_HOLD_EN
            md = 1;
            mm = 1;
            my = 0;
            wrap = 1'b1;
`endif
        end
    endtask

    function automatic logic [15:0] bcd4(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] bcd2(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        tick_seen <= bus.day_tick && rst_n;
    end

    always @(negedge clk) begin : monitor
        tick_exp_t te;
        set_exp_t  se;
        if (rst_n) begin
            if (tick_seen) begin
                if (tick_q.size() == 0) begin
                    check("tick_q_underflow", 1, 0);
                end else begin
                    te = tick_q.pop_front();
                    if (!te.drop) check("tick_date", dut_date(), te.date);
                    check("tick_year_wrap", int'(bus.year_wrap), int'(te.wrap));
                end
            end else begin
                check("no_spurious_wrap", int'(bus.year_wrap), 0);
            end
            if (bus.set_ack || bus.set_err) begin
                if (set_q.size() == 0) begin
                    check("set_q_underflow", 1, 0);
                end else begin
                    se = set_q.pop_front();
                    check("set_err", int'(bus.set_err), int'(se.err));
                    check("set_ack", int'(bus.set_ack), int'(!se.err));
                    check("set_date", dut_date(), se.date);
                    check("set_latency", cyc, se.cyc);
                    check("set_busy_clear", int'(bus.busy), 0);
                end
            end
        end
    end

    tick_exp_t drop_e = '{drop: 1'b1, date: 0, wrap: 1'b0};

    task automatic do_tick();
        tick_exp_t e;
        bit w;
        model_tick(w);
        e.drop = 1'b0;
        e.date = model_date();
        e.wrap = w;
        tick_q.push_back(e);
        bus.day_tick = 1'b1;
        @(negedge clk);
        bus.day_tick = 1'b0;
    endtask

    // tick_mode: 0 none, 1 same cycle as set_req, 2 during SET_LOAD, 3 during SET_CLAMP
    task automatic do_set(input logic [15:0] yb, input logic [7:0] mb, input logic [7:0] db,
                          input int tick_mode);
        set_exp_t e;
        bit ok;
        int y, m, d;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (yb[4*i +: 4] > 4'd9) ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (mb[4*i +: 4] > 4'd9) ok = 1'b0;
            if (db[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        bus.set_year  = yb;
        bus.set_month = mb;
        bus.set_day   = db;
        if (!ok) begin
            e.err = 1'b1;
            e.date = model_date();
            e.cyc = cyc + 1;
            set_q.push_back(e);
            bus.set_req = 1'b1;
            @(negedge clk);
            bus.set_req = 1'b0;
            @(negedge clk);
            return;
        end
        y = int'(yb[15:12]) * 1000 + int'(yb[11:8]) * 100 + int'(yb[7:4]) * 10 + int'(yb[3:0]);
        m = int'(mb[7:4]) * 10 + int'(mb[3:0]);
        d = int'(db[7:4]) * 10 + int'(db[3:0]);
        if (m == 0) m = 1;
        if (m > 12) m = 12;
        if (d == 0) d = 1;
        if (d > dim(y, m)) d = dim(y, m);
        my = y;
        mm = m;
        md = d;
        e.err = 1'b0;
        e.date = model_date();
        e.cyc = cyc + 3;
        set_q.push_back(e);
        bus.set_req = 1'b1;
        if (tick_mode == 1) begin
            tick_q.push_back(drop_e);
            bus.day_tick = 1'b1;
        end
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            bus.set_req  = 1'b0;
            bus.day_tick = 1'b0;
            if (tick_mode == c) begin
                tick_q.push_back(drop_e);
                bus.day_tick = 1'b1;
            end
        end
        @(negedge clk);
        bus.day_tick = 1'b0;
    endtask

    task automatic set_dec(input int y, input int m, input int d, input int tick_mode);
        do_set(bcd4(y), bcd2(m), bcd2(d), tick_mode);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.day_tick  = 1'b0;
        bus.set_req   = 1'b0;
        bus.set_day   = 8'h00;
        bus.set_month = 8'h00;
        bus.set_year  = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        my = 2000; mm = 1; md = 1;
        check("reset_date", dut_date(), 20000101);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_set_ack", int'(bus.set_ack), 0);
        check("reset_set_err", int'(bus.set_err), 0);
        check("reset_year_wrap", int'(bus.year_wrap), 0);

        set_dec(2005, 2, 28, 0); do_tick();
        set_dec(2004, 2, 28, 0); do_tick(); do_tick();
        set_dec(2000, 12, 31, 0); do_tick();
        set_dec(2099, 12, 31, 0); do_tick();
        set_dec(9999, 12, 31, 0); do_tick(); do_tick();
        set_dec(2100, 2, 30, 0);
        set_dec(2010, 13, 15, 0);
        set_dec(2011, 0, 0, 0);
        do_set(16'h2020, 8'h05, 8'h0A, 0);
        do_set(16'h20B0, 8'h05, 8'h10, 0);
        do_set(16'h2020, 8'hF1, 8'h10, 0);
        set_dec(2024, 3, 31, 1);
        set_dec(2024, 4, 30, 2);
        set_dec(2024, 6, 15, 3);
        do_tick();

        // Reset lands while the set is in SET_LOAD; the set must vanish without an ack.
        bus.set_year = 16'h1999; bus.set_month = 8'h07; bus.set_day = 8'h04;
        bus.set_req = 1'b1;
        @(negedge clk);
        bus.set_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        my = 2000; mm = 1; md = 1;
        check("rst_mid_set_date", dut_date(), 20000101);
        check("rst_mid_set_busy", int'(bus.busy), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid_set_no_ack", int'(bus.set_ack), 0);
        end

        for (int it = 0; it < 400; it++) begin
            int r, y, m, d;
            r = int'($urandom_range(0, 9));
            if (r <= 5) begin
                do_tick();
            end else if (r <= 7) begin
                y = int'($urandom_range(0, 9999));
                m = int'($urandom_range(0, 19));
                d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(27, 39)) : int'($urandom_range(0, 39));
                set_dec(y, m, d, int'($urandom_range(0, 3)));
            end else if (r == 8) begin
                logic [15:0] yb;
                logic [7:0]  mb, db;
                yb = bcd4(int'($urandom_range(0, 9999)));
                mb = bcd2(int'($urandom_range(1, 12)));
                db = bcd2(int'($urandom_range(1, 28)));
                case ($urandom_range(0, 2))
                    0:       yb[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
                    1:       mb[4*$urandom_range(0, 1) +: 4] = 4'($urandom_range(10, 15));
                    default: db[4*$urandom_range(0, 1) +: 4] = 4'($urandom_range(10, 15));
                endcase
                do_set(yb, mb, db, 0);
            end else begin
                y = ($urandom_range(0, 1) == 1) ? 9999 : int'($urandom_range(0, 99)) * 100 + 99;
                set_dec(y, 12, int'($urandom_range(30, 31)), 0);
            end
        end

        repeat (4) @(negedge clk);
        check("tick_q_drained", tick_q.size(), 0);
        check("set_q_drained", set_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
